bp_be_issue_ctrl: RTL and testbench

Backend issue controller sitting directly downstream of the checkpointing FE queue. It consumes the queue head and tracks register hazards with a scoreboard fed by the queue's early rs1/rs2 addresses. It issues instructions into a registered dispatch slot. It also generates the queue's read (yumi), commit (deq), roll and clear controls from backend commit, flush and redirect events.

---
 rtl/bp_be_issue_ctrl_pkg.sv | 17 +
 rtl/bp_be_scoreboard.sv | 52 +++++
 rtl/bp_be_issue_ctrl.sv | 118 +++++++++++
 tb/tb_bp_be_issue_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_issue_ctrl_pkg.sv
// Shared constants and types for the backend issue controller and its scoreboard.
package bp_be_issue_ctrl_pkg;

  localparam int unsigned fe_queue_width_lp = 128;
  localparam int unsigned fifo_els_lp       = 8;
  localparam int unsigned reg_addr_width_lp = 5;
  localparam int unsigned sb_els_lp         = 32;
  localparam int unsigned x0_idx_lp         = 0;

  typedef logic [fe_queue_width_lp-1:0] dispatch_pkt_t;

  // A counter has to hold every value from zero up to and including els.
  function automatic int unsigned cnt_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bp_be_scoreboard.sv
// Register busy bits: set on issue, cleared on writeback, wiped on flush.
// The x0 bit is never set and always reads as idle.
module bp_be_scoreboard
  import bp_be_issue_ctrl_pkg::*;
#(
  parameter int unsigned reg_els_p        = sb_els_lp,
  parameter int unsigned reg_addr_width_p = reg_addr_width_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        set_v_i,
  input  logic [reg_addr_width_p-1:0] set_addr_i,
  input  logic                        clr_v_i,
  input  logic [reg_addr_width_p-1:0] clr_addr_i,
  input  logic                        flush_i,
  input  logic [reg_addr_width_p-1:0] rs1_addr_i,
  input  logic [reg_addr_width_p-1:0] rs2_addr_i,
  output logic                        rs1_busy_o,
  output logic                        rs2_busy_o
);

  localparam logic [reg_addr_width_p-1:0] x0_addr_lp = reg_addr_width_p'(x0_idx_lp);

  logic [reg_els_p-1:0] sb_q, sb_d;

  // Clear is applied before set so a same-cycle issue to the written register stays busy.
  always_comb begin
    sb_d = sb_q;
    if (clr_v_i) begin
      sb_d[clr_addr_i] = 1'b0;
    end
    if (set_v_i && (set_addr_i != x0_addr_lp)) begin
      sb_d[set_addr_i] = 1'b1;
    end
    if (flush_i) begin
      sb_d = '0;
    end
    sb_d[x0_idx_lp] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign rs1_busy_o = (rs1_addr_i != x0_addr_lp) & sb_q[rs1_addr_i];
  assign rs2_busy_o = (rs2_addr_i != x0_addr_lp) & sb_q[rs2_addr_i];

endmodule

// File: rtl/bp_be_issue_ctrl.sv
// Backend issue controller: hazard-checked issue from the FE queue head into a
// registered dispatch slot, plus FE queue deq/roll/clr generation.
module bp_be_issue_ctrl
  import bp_be_issue_ctrl_pkg::*;
#(
  parameter int unsigned fe_queue_width_p = fe_queue_width_lp,
  parameter int unsigned fifo_els_p       = fifo_els_lp,
  parameter int unsigned reg_addr_width_p = reg_addr_width_lp,
  parameter int unsigned reg_els_p        = sb_els_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [fe_queue_width_p-1:0] fe_queue_i,
  input  logic                        fe_queue_v_i,
  output logic                        fe_queue_yumi_o,
  input  logic [reg_addr_width_p-1:0] rs1_addr_i,
  input  logic [reg_addr_width_p-1:0] rs2_addr_i,
  input  logic                        rs1_v_i,
  input  logic                        rs2_v_i,
  input  logic [reg_addr_width_p-1:0] rd_addr_i,
  input  logic                        rd_w_v_i,
  output logic                        deq_v_o,
  output logic                        roll_v_o,
  output logic                        clr_v_o,
  input  logic                        commit_v_i,
  input  logic                        flush_v_i,
  input  logic                        redirect_v_i,
  input  logic                        wb_v_i,
  input  logic [reg_addr_width_p-1:0] wb_addr_i,
  output logic [fe_queue_width_p-1:0] dispatch_pkt_o,
  output logic                        dispatch_v_o,
  input  logic                        dispatch_yumi_i
);

  localparam int unsigned cnt_w_lp = cnt_width(fifo_els_p);
  localparam logic [cnt_w_lp-1:0] max_inflight_lp = cnt_w_lp'(fifo_els_p);

  logic [reg_addr_width_p-1:0] rs1_q, rs2_q;
  logic [cnt_w_lp-1:0]         inflight_q, inflight_d;
  logic                        dispatch_v_q, dispatch_v_d;
  logic [fe_queue_width_p-1:0] dispatch_pkt_q, dispatch_pkt_d;
  logic                        rs1_busy, rs2_busy, hazard, slot_free, issue;

  bp_be_scoreboard #(
    .reg_els_p       (reg_els_p),
    .reg_addr_width_p(reg_addr_width_p)
  ) u_sb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .set_v_i   (issue & rd_w_v_i),
    .set_addr_i(rd_addr_i),
    .clr_v_i   (wb_v_i),
    .clr_addr_i(wb_addr_i),
    .flush_i   (flush_v_i),
    .rs1_addr_i(rs1_q),
    .rs2_addr_i(rs2_q),
    .rs1_busy_o(rs1_busy),
    .rs2_busy_o(rs2_busy)
  );

  // Every combinational output is gated by reset so nothing leaks out while it is held.
  assign hazard    = rs1_busy | rs2_busy;
  assign slot_free = ~dispatch_v_q | dispatch_yumi_i;
  assign issue     = reset_i & fe_queue_v_i & ~hazard & slot_free
                   & (inflight_q < max_inflight_lp) & ~flush_v_i & ~redirect_v_i;

  assign fe_queue_yumi_o = issue;
  assign deq_v_o         = reset_i & commit_v_i & (inflight_q != '0);
  assign roll_v_o        = reset_i & flush_v_i;
  assign clr_v_o         = reset_i & redirect_v_i;
  assign dispatch_v_o    = dispatch_v_q;
  assign dispatch_pkt_o  = dispatch_pkt_q;

  always_comb begin
    inflight_d     = inflight_q;
    dispatch_v_d   = dispatch_v_q;
    dispatch_pkt_d = dispatch_pkt_q;
    if (flush_v_i) begin
      inflight_d = '0;
    end else if (issue && !deq_v_o && (inflight_q != max_inflight_lp)) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue && deq_v_o) begin
      inflight_d = inflight_q - 1'b1;
    end
    if (flush_v_i) begin
      dispatch_v_d = 1'b0;
    end else if (issue) begin
      dispatch_v_d   = 1'b1;
      dispatch_pkt_d = fe_queue_i;
    end else if (dispatch_yumi_i) begin
      dispatch_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rs1_q          <= '0;
      rs2_q          <= '0;
      inflight_q     <= '0;
      dispatch_v_q   <= 1'b0;
      dispatch_pkt_q <= '0;
    end else begin
      if (rs1_v_i) rs1_q <= rs1_addr_i;
      if (rs2_v_i) rs2_q <= rs2_addr_i;
      inflight_q     <= inflight_d;
      dispatch_v_q   <= dispatch_v_d;
      dispatch_pkt_q <= dispatch_pkt_d;
    end
  end

  // A commit with nothing in flight means the backend and queue disagree.
  always_ff @(posedge clk_i) begin
    if (reset_i && commit_v_i) begin
      assert (inflight_q != '0);
    end
  end

endmodule

// File: tb/tb_bp_be_issue_ctrl.sv
// Directed self-checking bench for bp_be_issue_ctrl with hand-computed expectations.
module tb_bp_be_issue_ctrl;
  import bp_be_issue_ctrl_pkg::*;

  logic          clk_i = 1'b0;
  logic          reset_i;
  dispatch_pkt_t fe_queue_i;
  logic          fe_queue_v_i, fe_queue_yumi_o;
  logic [4:0]    rs1_addr_i, rs2_addr_i, rd_addr_i, wb_addr_i;
  logic          rs1_v_i, rs2_v_i, rd_w_v_i;
  logic          deq_v_o, roll_v_o, clr_v_o;
  logic          commit_v_i, flush_v_i, redirect_v_i, wb_v_i;
  dispatch_pkt_t dispatch_pkt_o;
  logic          dispatch_v_o, dispatch_yumi_i;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk_i = ~clk_i;

  bp_be_issue_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_yumi_o(fe_queue_yumi_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rs1_v_i(rs1_v_i), .rs2_v_i(rs2_v_i),
    .rd_addr_i(rd_addr_i), .rd_w_v_i(rd_w_v_i),
    .deq_v_o(deq_v_o), .roll_v_o(roll_v_o), .clr_v_o(clr_v_o),
    .commit_v_i(commit_v_i), .flush_v_i(flush_v_i), .redirect_v_i(redirect_v_i),
    .wb_v_i(wb_v_i), .wb_addr_i(wb_addr_i),
    .dispatch_pkt_o(dispatch_pkt_o), .dispatch_v_o(dispatch_v_o),
    .dispatch_yumi_i(dispatch_yumi_i)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idleInputs();
    fe_queue_i = '0; fe_queue_v_i = 0; rd_addr_i = 0; rd_w_v_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rs1_v_i = 0; rs2_v_i = 0;
    commit_v_i = 0; flush_v_i = 0; redirect_v_i = 0;
    wb_v_i = 0; wb_addr_i = 0;
  endtask

  task automatic applyStimulus(input logic fev, input dispatch_pkt_t pkt,
                               input logic rdw, input logic [4:0] rd);
    fe_queue_v_i = fev; fe_queue_i = pkt; rd_w_v_i = rdw; rd_addr_i = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b0;
    dispatch_yumi_i = 1'b1;
    idleInputs();
    commit_v_i = 1; flush_v_i = 1; redirect_v_i = 1;
    applyStimulus(1, 128'hAAAA, 1, 5'd3);
    checkOutput("rst_yumi", fe_queue_yumi_o, 0);
    checkOutput("rst_deq", deq_v_o, 0);
    checkOutput("rst_roll", roll_v_o, 0);
    checkOutput("rst_clr", clr_v_o, 0);
    tick();
    tick();
    checkOutput("rst_dv", dispatch_v_o, 0);
    reset_i = 1'b1;
    idleInputs();
    #1;
    checkOutput("post_rst_dv", dispatch_v_o, 0);
    checkOutput("post_rst_inflight", dut.inflight_q, 0);

    // RAW hazard on x5 held until writeback, no same-cycle bypass
    rs1_v_i = 1; rs1_addr_i = 5'd5; rs2_v_i = 1; rs2_addr_i = 5'd0;
    applyStimulus(1, 128'hA0, 1, 5'd5);
    checkOutput("raw_first_yumi", fe_queue_yumi_o, 1);
    tick();
    rs1_v_i = 0; rs2_v_i = 0;
    checkOutput("raw_first_pkt", dispatch_pkt_o, 128'hA0);
    applyStimulus(1, 128'hB0, 0, 5'd0);
    checkOutput("raw_stall", fe_queue_yumi_o, 0);
    tick();
    wb_v_i = 1; wb_addr_i = 5'd5;
    #1;
    checkOutput("raw_no_bypass", fe_queue_yumi_o, 0);
    tick();
    wb_v_i = 0; rs1_v_i = 1; rs1_addr_i = 5'd0;
    #1;
    checkOutput("raw_release", fe_queue_yumi_o, 1);
    tick();
    rs1_v_i = 0;
    checkOutput("raw_second_pkt", dispatch_pkt_o, 128'hB0);
    checkOutput("raw_inflight", dut.inflight_q, 2);
    applyStimulus(0, '0, 0, 5'd0);
    commit_v_i = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput($sformatf("raw_deq%0d", i), deq_v_o, 1);
      tick();
    end
    commit_v_i = 0;
    #1;
    checkOutput("raw_drained", dut.inflight_q, 0);

    // Fill to the in-flight limit
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, dispatch_pkt_t'(128'h100 + i), 0, 5'd0);
      checkOutput($sformatf("fill_yumi%0d", i), fe_queue_yumi_o, 1);
      tick();
    end
    checkOutput("fill_inflight", dut.inflight_q, 8);
    applyStimulus(1, 128'h200, 0, 5'd0);
    checkOutput("full_hold", fe_queue_yumi_o, 0);
    tick();
    commit_v_i = 1;
    #1;
    checkOutput("full_deq", deq_v_o, 1);
    checkOutput("full_deq_yumi", fe_queue_yumi_o, 0);
    tick();
    commit_v_i = 0;
    #1;
    checkOutput("full_resume", fe_queue_yumi_o, 1);
    tick();
    checkOutput("full_resume_pkt", dispatch_pkt_o, 128'h200);
    checkOutput("full_inflight", dut.inflight_q, 8);
    applyStimulus(0, '0, 0, 5'd0);
    commit_v_i = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput($sformatf("drain_deq%0d", i), deq_v_o, 1);
      tick();
    end
    commit_v_i = 0;
    #1;
    checkOutput("drain_inflight", dut.inflight_q, 0);
    checkOutput("drain_dv", dispatch_v_o, 0);

    // Dispatch backpressure, then back-to-back issue
    dispatch_yumi_i = 0;
    applyStimulus(1, 128'hC1, 1, 5'd1);
    checkOutput("bp_first_yumi", fe_queue_yumi_o, 1);
    tick();
    applyStimulus(1, 128'hC2, 1, 5'd2);
    checkOutput("bp_hold_yumi", fe_queue_yumi_o, 0);
    tick();
    checkOutput("bp_hold_pkt0", dispatch_pkt_o, 128'hC1);
    tick();
    checkOutput("bp_hold_pkt1", dispatch_pkt_o, 128'hC1);
    checkOutput("bp_hold_dv", dispatch_v_o, 1);
    dispatch_yumi_i = 1;
    #1;
    checkOutput("b2b_yumi0", fe_queue_yumi_o, 1);
    tick();
    checkOutput("b2b_pkt0", dispatch_pkt_o, 128'hC2);
    applyStimulus(1, 128'hC3, 1, 5'd3);
    checkOutput("b2b_yumi1", fe_queue_yumi_o, 1);
    tick();
    checkOutput("b2b_pkt1", dispatch_pkt_o, 128'hC3);
    checkOutput("pre_flush_inflight", dut.inflight_q, 3);
    checkOutput("pre_flush_sb", dut.u_sb.sb_q, 32'h0000_000E);

    // Flush with a coincident commit
    applyStimulus(1, 128'hC4, 0, 5'd0);
    flush_v_i = 1; commit_v_i = 1;
    #1;
    checkOutput("flush_roll", roll_v_o, 1);
    checkOutput("flush_deq", deq_v_o, 1);
    checkOutput("flush_yumi", fe_queue_yumi_o, 0);
    checkOutput("flush_clr", clr_v_o, 0);
    tick();
    flush_v_i = 0; commit_v_i = 0;
    applyStimulus(0, '0, 0, 5'd0);
    checkOutput("post_flush_inflight", dut.inflight_q, 0);
    checkOutput("post_flush_sb", dut.u_sb.sb_q, 0);
    checkOutput("post_flush_dv", dispatch_v_o, 0);

    // Redirect, then same-cycle set/clear of one register
    applyStimulus(1, 128'hD0, 1, 5'd9);
    checkOutput("redir_pre_yumi", fe_queue_yumi_o, 1);
    tick();
    redirect_v_i = 1;
    applyStimulus(1, 128'hD1, 1, 5'd4);
    checkOutput("redir_clr", clr_v_o, 1);
    checkOutput("redir_yumi", fe_queue_yumi_o, 0);
    checkOutput("redir_roll", roll_v_o, 0);
    tick();
    redirect_v_i = 0;
    checkOutput("redir_sb", dut.u_sb.sb_q, 32'h0000_0200);
    checkOutput("redir_inflight", dut.inflight_q, 1);
    wb_v_i = 1; wb_addr_i = 5'd7;
    applyStimulus(1, 128'hD2, 1, 5'd7);
    checkOutput("setwin_yumi", fe_queue_yumi_o, 1);
    tick();
    wb_v_i = 0;
    checkOutput("setwin_sb", dut.u_sb.sb_q, 32'h0000_0280);

    // Asynchronous mid-operation reset
    #2;
    reset_i = 1'b0;
    #1;
    checkOutput("async_rst_inflight", dut.inflight_q, 0);
    checkOutput("async_rst_sb", dut.u_sb.sb_q, 0);
    checkOutput("async_rst_dv", dispatch_v_o, 0);
    checkOutput("async_rst_pkt", dispatch_pkt_o, 0);
    checkOutput("async_rst_yumi", fe_queue_yumi_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
